des_sbox_bank: RTL and testbench

- Complete DES S-box substitution stage: S1..S8 applied to the 48-bit expanded-XOR value, giving the 32-bit Feistel f-function pre-permutation result.
- Time-multiplexed over LANES parallel lookups per cycle, so one parameter trades area against latency.
- Sits between the key-mix XOR and the P permutation in the round datapath.
- Uses a valid/ready handshake on both sides so it can be stalled by the round controller.

---
 rtl/des_sbox_bank.sv | 162 ++++++++++++++++
 tb/tb_des_sbox_bank.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/des_sbox_bank.sv
// DES S1..S8 substitution stage, LANES lookups per cycle, valid/ready both sides.
// Ports: clk, rst (sync high), in_valid/in_ready/in_data[47:0], out_valid/out_ready/out_data[31:0].
// Optional: define DES_SBOX_PBOX_EN to route the result through the DES P permutation.
module des_sbox_bank #(
  parameter int LANES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int STEPS = (LANES > 0) ? 8 / LANES : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("des_sbox_bank: LANES must be 1, 2, 4 or 8");
  end

  // S1..S8 back to back; entry index = {sbox, row[1:0], col[3:0]}
  localparam logic [3:0] SBOX [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
  };

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [47:0] data_q, data_d;
  logic [31:0] res_q, res_d;

  logic [2:0]  idx;
  logic [5:0]  chunk;
  logic [5:0]  dbase;
  logic [4:0]  rbase;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    idx       = '0;
    chunk     = '0;
    dbase     = '0;
    rbase     = '0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          idx   = 3'(int'(cnt_q) * LANES + l);
          dbase = 6'(47 - 6 * int'(idx));
          // 31 - 4*idx
          rbase = {~idx, 2'b11};
          chunk = data_q[dbase -: 6];
          res_d[rbase -: 4] = SBOX[{idx, chunk[5], chunk[0], chunk[4:1]}];
        end
        if (cnt_q == 3'(STEPS - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // accept the next block in the same cycle the result leaves
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            data_d  = in_data;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      res_q   <= res_d;
    end
  end

`ifdef DES_SBOX_PBOX_EN
  // output bit i (1 = MSB) takes result bit PTAB[i-1]
  localparam int PTAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  always_comb begin
    out_data = '0;
    for (int i = 0; i < 32; i++) begin
      out_data[5'(31 - i)] = res_q[5'(32 - PTAB[i])];
    end
  end
`else
  assign out_data = res_q;
`endif

endmodule

// File: tb/tb_des_sbox_bank.sv
// Directed bench for des_sbox_bank: one instance per LANES value (1,2,4,8).
// Expected results are hand-derived from the FIPS 46-3 S-box tables.
module tb_des_sbox_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid_a  [4];
  logic        in_ready_a  [4];
  logic [47:0] in_data_a   [4];
  logic        out_valid_a [4];
  logic        out_ready_a [4];
  logic [31:0] out_data_a  [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_bank #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in_data   (in_data_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .out_data  (out_data_a[g])
    );
  end

  int n_chk = 0;
  int n_err = 0;

  localparam logic [47:0] V_ZERO = 48'h000000000000;
  localparam logic [47:0] V_ONES = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] V_A    = 48'h06085E0BF56A;
  localparam logic [47:0] V_B    = 48'hD8BE07B50919;
  localparam logic [31:0] R_ZERO = 32'hEFA72C4D;
  localparam logic [31:0] R_ONES = 32'hD9CE3DCB;
  localparam logic [31:0] R_A    = 32'h001FCD5C;
  localparam logic [31:0] R_B    = 32'h725520B0;

  function automatic logic [31:0] pmap(input logic [31:0] r);
`ifdef DES_SBOX_PBOX_EN
    int pt [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,
       1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,
      19, 13, 30,  6, 22, 11,  4, 25
    };
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[31-i] = r[32-pt[i]];
    return o;
`else
    return r;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // wait (bounded) for in_ready with in_valid high; returns at the negedge
  // just after the accepting edge
  task automatic accept(input int k, input logic [47:0] d);
    int n;
    in_valid_a[k] = 1'b1;
    in_data_a[k]  = d;
    n = 0;
    while (!in_ready_a[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 50), 32'd1);
    @(negedge clk);
  endtask

  // count cycles to out_valid; in_valid stays high with garbage data
  task automatic wait_result(input int k, input logic [47:0] d,
                             input logic [31:0] exp);
    int lat;
    logic rdy_bad;
    in_data_a[k] = ~d;
    lat = 0;
    rdy_bad = 1'b0;
    while (!out_valid_a[k] && lat < 40) begin
      if (in_ready_a[k]) rdy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(8 >> k));
    check("busy_in_ready", 32'(rdy_bad), 32'd0);
    check("data", out_data_a[k], pmap(exp));
    in_valid_a[k] = 1'b0;
  endtask

  task automatic run_block(input int k, input logic [47:0] d,
                           input logic [31:0] exp, input int stall);
    @(negedge clk);
    out_ready_a[k] = 1'b0;
    accept(k, d);
    wait_result(k, d, exp);
    repeat (stall) @(negedge clk);
    check("hold_data", out_data_a[k], pmap(exp));
    check("hold_valid", 32'(out_valid_a[k]), 32'd1);
    check("hold_in_ready", 32'(in_ready_a[k]), 32'd0);
    out_ready_a[k] = 1'b1;
    @(negedge clk);
    out_ready_a[k] = 1'b0;
    check("valid_drop", 32'(out_valid_a[k]), 32'd0);
    check("idle_in_ready", 32'(in_ready_a[k]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid_a[k]  = 1'b0;
      in_data_a[k]   = '0;
      out_ready_a[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_in_ready", 32'(in_ready_a[k]), 32'd1);
      check("rst_out_valid", 32'(out_valid_a[k]), 32'd0);
      check("rst_out_data", out_data_a[k], 32'd0);
    end

    // every width over the four directed vectors, with varied stalls
    for (int k = 0; k < 4; k++) begin
      run_block(k, V_ZERO, R_ZERO, 0);
      run_block(k, V_ONES, R_ONES, 3);
      run_block(k, V_A, R_A, 1);
      run_block(k, V_B, R_B, 2);
    end

    // LANES=2: long stall, then back-to-back handoff
    @(negedge clk);
    accept(1, V_ZERO);
    wait_result(1, V_ZERO, R_ZERO);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b2b_stall_data", out_data_a[1], pmap(R_ZERO));
      check("b2b_stall_ready", 32'(in_ready_a[1]), 32'd0);
    end
    out_ready_a[1] = 1'b1;
    in_valid_a[1]  = 1'b1;
    in_data_a[1]   = V_ONES;
    #1;
    check("b2b_in_ready", 32'(in_ready_a[1]), 32'd1);
    @(negedge clk);
    out_ready_a[1] = 1'b0;
    check("b2b_valid_drop", 32'(out_valid_a[1]), 32'd0);
    wait_result(1, V_ONES, R_ONES);
    out_ready_a[1] = 1'b1;
    @(negedge clk);
    out_ready_a[1] = 1'b0;
    check("b2b_idle", 32'(in_ready_a[1]), 32'd1);

    // LANES=4: reset in the second busy cycle discards the block
    @(negedge clk);
    accept(2, V_ONES);
    in_valid_a[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid_a[2]), 32'd0);
    check("mid_rst_ready", 32'(in_ready_a[2]), 32'd1);
    check("mid_rst_data", out_data_a[2], 32'd0);
    repeat (3) @(negedge clk);
    check("mid_rst_no_valid", 32'(out_valid_a[2]), 32'd0);
    run_block(2, V_ZERO, R_ZERO, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
